// File: rtl/shift_rx.sv
// shift_rx: serial-to-parallel word receiver.
// Frames a serial bit stream on a start strobe, assembles WIDTH bits MSB-first,
// and presents each completed word in a holding register with a valid/read
// handshake, sticky overrun flag and a restart (abort) pulse.
// Optional feature macro: PARITY_EN adds one even-parity bit per frame and
// drives perr. Without it, frames are exactly WIDTH bits and perr is tied 0.
module shift_rx #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             di,
    input  logic             en,
    input  logic             start,
    input  logic             rd,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy,
    output logic             ovr,
    output logic             abort,
    output logic             perr
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] word;
    logic             deliver;
    logic             abort_nxt;
`ifdef PARITY_EN
    logic             par_err;
`endif

    // Next-state, shift and delivery decode for one en-qualified bit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        word      = sr;
        deliver   = 1'b0;
        abort_nxt = 1'b0;
`ifdef PARITY_EN
        par_err   = 1'b0;
`endif
        if (en) begin
            if (start) begin
                // A start always begins a new frame; mid-frame it discards the partial one.
                sr_nxt    = {sr[WIDTH-2:0], di};
                cnt_nxt   = CW'(1);
                state_nxt = DATA;
                abort_nxt = (state != IDLE);
            end else begin
                case (state)
                    DATA: begin
                        sr_nxt  = {sr[WIDTH-2:0], di};
                        cnt_nxt = cnt + CW'(1);
                        if (cnt == LAST_IDX) begin
`ifdef PARITY_EN
                            state_nxt = PAR;
`else
                            deliver   = 1'b1;
                            word      = sr_nxt;
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
`endif
                        end
                    end
`ifdef PARITY_EN
                    PAR: begin
                        // Even parity: data bits plus parity bit must XOR to 0.
                        deliver   = 1'b1;
                        word      = sr;
                        par_err   = ^{sr, di};
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
`endif
                    default: ;  // IDLE without start: bit is discarded
                endcase
            end
        end
    end

    // Frame state register: FSM state, shift register and bit counter.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Holding register and handshake flags; all outputs are registered.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q     <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            ovr   <= 1'b0;
            abort <= 1'b0;
        end else begin
            busy  <= (state_nxt != IDLE);
            abort <= abort_nxt;
            if (deliver) begin
                // Newest word always wins; an unread previous word marks overrun
                // unless it is acknowledged on this same edge.
                q     <= word;
                valid <= 1'b1;
                if (rd)
                    ovr <= 1'b0;
                else if (valid)
                    ovr <= 1'b1;
            end else if (rd) begin
                valid <= 1'b0;
                ovr   <= 1'b0;
            end
        end
    end

`ifdef PARITY_EN
    // Parity flag describes the word in q, so it changes only on delivery.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            perr <= 1'b0;
        else if (deliver)
            perr <= par_err;
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: doc/shift_rx.md
# shift_rx

Serial-to-parallel word receiver. It is the receiving end of the team's parallel-load shift register, whose serial output `do` drives this block's `di`. The block frames a bit stream on a start strobe and assembles WIDTH bits MSB-first. It then presents each completed word in a holding register with a valid/read handshake and overrun detection.

## Interface
- WIDTH, 3, data bits per frame; legal range 2..16.
- clk  input  1  clock; all state changes on the rising edge.
- clrn  input  1  reset, asynchronous, active-low.
- di  input  1  serial data in; sampled only when `en`=1.
- en  input  1  bit strobe; one bit is consumed per cycle with `en`=1.
- start  input  1  marks the current `di` bit as the first bit of a frame; ignored when `en`=0.
- rd  input  1  consumer acknowledge; clears `valid` and `ovr`.
- q  output  WIDTH  last completed word, held until the next delivery.
- valid  output  1  word available in `q`, not yet read.
- busy  output  1  frame in progress.
- ovr  output  1  sticky overrun: a word was delivered while `valid`=1 and `rd`=0.
- abort  output  1  one-cycle pulse: a frame was restarted mid-frame.
- perr  output  1  parity error of the word in `q`; tied 0 without PARITY_EN.

## Operation
- States: IDLE, DATA, and PAR (PAR exists only with PARITY_EN). Internal shift register `sr[WIDTH-1:0]` and bit counter `cnt`, sized ceil(log2(WIDTH+1)).
- IDLE, `en`=1 and `start`=1: `sr` <= {sr[WIDTH-2:0], di}, `cnt`=1, next state DATA. With `en`=1 and `start`=0, bits are discarded and the state stays IDLE.
- DATA, `en`=1, `start`=0: shift `di` into `sr` LSB, so the first bit ends in the MSB, and increment `cnt`.
  - When this is the WIDTH-th bit: deliver and go to IDLE, or go to PAR with PARITY_EN.
- PAR, `en`=1, `start`=0: sample the parity bit, deliver, go to IDLE.
- `start`=1 with `en`=1 in DATA or PAR: discard the partial frame, pulse `abort`, take `di` as bit 1 of a new frame (`cnt`=1, state DATA).
- `en`=0 in any state: hold all state.
- Delivery:
  - `q` <= assembled word.
  - `valid` <= 1.
  - If `valid`=1 and `rd`=0 on the same edge, `ovr` <= 1; the new word still overwrites `q` (newest wins).
- `rd`=1 without a delivery on the same edge: `valid` <= 0, `ovr` <= 0.
- `rd`=1 with a delivery on the same edge: `valid` stays 1, `ovr` <= 0.
- `rd` while `valid`=0 has no effect.
- `busy` = 1 in DATA and PAR, 0 in IDLE. It is registered as a state decode.

## Timing
- Reset (`clrn`=0, any time including mid-frame): state IDLE, `sr`=0, `cnt`=0, `q`=0, `valid`=0, `busy`=0, `ovr`=0, `abort`=0, `perr`=0. The partial frame is lost and no delivery occurs.
- Latency: `q`/`valid` update on the same rising edge that samples the last bit (data bit WIDTH, or the parity bit) with `en`=1. They are visible for the whole following cycle.
- With `en` tied 1, a frame is WIDTH cycles (WIDTH+1 with PARITY_EN). Back-to-back frames need no idle gap: a `start` in the cycle after delivery is accepted from IDLE.
- `abort` is high for exactly one cycle after the restarting edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- PARITY_EN defined:
  - Each frame carries one extra bit after the data: even parity over data plus parity bit.
  - `perr` <= 1 on delivery if the XOR of all WIDTH+1 bits is 1, else 0.
  - `perr` changes only on delivery or reset.
- PARITY_EN undefined: PAR state and parity logic are absent, frames are exactly WIDTH bits, and `perr` is constant 0.

## Test plan
- Reset: assert `clrn`=0 mid-frame with `valid`=1 -> all outputs 0 immediately (asynchronous); the next frame is assembled cleanly.
- WIDTH=3, `en`=1, `start` with bit 1, bits 1,0,1 -> after the 3rd edge `q`=101, `valid`=1, `busy`=0; `rd` pulse -> `valid`=0.
- Same frame with `en` high every other cycle and `di` toggling on `en`=0 cycles -> `q`=101; bits presented while `en`=0 are ignored.
- Frames 110 then 011, no `rd` -> `q`=011, `valid`=1, `ovr`=1; `rd` -> `valid`=0, `ovr`=0. Delivery coincident with `rd` -> `valid`=1, `ovr`=0.
- `start` on the 2nd bit of a frame, then bits 0,1,0 -> `abort` high one cycle, `q`=010, no delivery of the aborted frame.
- PARITY_EN, data 101 + parity 0 -> `q`=101, `perr`=0; data 101 + parity 1 -> `perr`=1. 4 `en` cycles per frame.
